// File: rtl/level_countdown_timer.sv
// Per-level countdown timer: loads a level-dependent duration on start_timer,
// counts whole seconds down in BCD and pulses timerend when the count hits 00.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset; digits 00, not running
// RUN     | counting (or frozen); running=1
// EXPIRED | reached 00, timerend pulsed; digits hold 00 until restart
module level_countdown_timer #(
    parameter int TICKS_PER_SEC = 31500000,
    parameter int BASE_TIME     = 60,
    parameter int TIME_STEP     = 8,
    parameter int MIN_TIME      = 20,
    parameter int WARN_TIME     = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_timer,
    input  logic [2:0] level,
    input  logic       freeze,
    output logic       timerend,
    output logic       running,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       warning,
    output logic       blink
);

    localparam int DIV_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_SEC - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICKS_PER_SEC / 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             timerend_q, timerend_d;

    logic [6:0]       dur;
    logic [3:0]       load_tens;
    logic [3:0]       load_ones;
    logic [6:0]       remaining;
    logic             last_sec;

    // Signed int arithmetic so a high level can never wrap below MIN_TIME.
    function automatic logic [6:0] duration(input logic [2:0] lvl_in);
        int lvl;
        int d;
        lvl = (lvl_in == 3'd0) ? 1 : int'(lvl_in);
        d   = BASE_TIME - (lvl - 1) * TIME_STEP;
        if (d < MIN_TIME) begin
            d = MIN_TIME;
        end
        return 7'(d);
    endfunction

    always_comb begin
        dur       = duration(level);
        load_tens = 4'(dur / 7'd10);
        load_ones = 4'(dur % 7'd10);
    end

    assign remaining = 7'({3'b000, tens_q} * 7'd10) + {3'b000, ones_q};
    assign last_sec  = (tens_q == 4'd0) && (ones_q <= 4'd1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            div_q      <= '0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            timerend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            timerend_q <= timerend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        timerend_d = 1'b0;

        if (start_timer) begin
            state_d = RUN;
            div_d   = '0;
            tens_d  = load_tens;
            ones_d  = load_ones;
        end else begin
            case (state_q)
                RUN: begin
                    if (!freeze) begin
                        if (div_q == DIV_LAST) begin
                            div_d = '0;
                            if (last_sec) begin
                                // Also catches a stray 00 so the digits never underflow.
                                tens_d     = 4'd0;
                                ones_d     = 4'd0;
                                state_d    = EXPIRED;
                                timerend_d = (ones_q == 4'd1);
                            end else if (ones_q != 4'd0) begin
                                ones_d = ones_q - 4'd1;
                            end else begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end
                default: begin
                    state_d = IDLE;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end
            endcase
        end
    end

    assign timerend = timerend_q;
    assign running  = (state_q == RUN);
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign warning  = running && (int'(remaining) <= WARN_TIME);
    assign blink    = warning && (div_q < DIV_HALF);

endmodule
